// File: rtl/seg_display_pkg.sv
// Shared segment codes, controller state encoding and helper functions for seg_display_ctrl.
// Pure declarations; no latency and no flow control involved.
package seg_display_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble: start loads bin, then one bit per cycle for DATA_W cycles; done is high
// during the last shift cycle, so bcd/ovf are final the cycle after. No backpressure: start restarts it.
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int D      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic [4*D-1:0]    bcd,
  output logic              ovf,
  output logic              done
);

  localparam int BCD_W = 4 * D;
  localparam int CNT_W = clog2(DATA_W + 1);

  logic [DATA_W-1:0] sr;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj;
  logic              ovf_q;
  logic              running;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    adj = '0;
    for (int k = 0; k < D; k++) begin
      adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
  end

  assign done = running && (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      sr      <= bin;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      sr    <= {sr[DATA_W-2:0], 1'b0};
      bcd_q <= {adj[BCD_W-2:0], sr[DATA_W-1]};
      // A carry out of the top digit means the value no longer fits in D digits
      ovf_q <= ovf_q | adj[BCD_W-1];
      cnt   <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  assign bcd = bcd_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-field 7-segment controller: per-field capture, round-robin share of one serial BCD converter.
// Load-to-display latency DATA_W+3 cycles; loads are never refused, a newer load overwrites a pending one.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_FIELDS       = 4,
  parameter int DIGITS_PER_FIELD = 2,
  parameter int DATA_W           = 32,
  parameter int BLANK_LZ         = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_FIELDS-1:0]                    field_load,
  input  logic [NUM_FIELDS*DATA_W-1:0]             field_value,
  output logic [NUM_FIELDS*DIGITS_PER_FIELD*7-1:0] hex_o,
  output logic [NUM_FIELDS-1:0]                    overflow,
  output logic                                     busy
);

  localparam int D     = DIGITS_PER_FIELD;
  localparam int SEL_W = (NUM_FIELDS > 1) ? clog2(NUM_FIELDS) : 1;
  localparam int HEX_W = NUM_FIELDS * D * 7;

  function automatic logic [HEX_W-1:0] hex_reset();
    logic [HEX_W-1:0] h;
    h = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      for (int k = 0; k < D; k++) begin
        h[(i*D+k)*7 +: 7] = (k == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
      end
    end
    return h;
  endfunction

  localparam logic [HEX_W-1:0] HEX_RST = hex_reset();

  state_t              state, state_nxt;
  logic [NUM_FIELDS-1:0] pend;
  logic [DATA_W-1:0]   pend_val [NUM_FIELDS];
  logic [SEL_W-1:0]    sel, rr_ptr, pick;
  logic                pick_vld;
  logic                conv_start, conv_done, conv_ovf;
  logic [4*D-1:0]      conv_bcd;
  logic [D*7-1:0]      seg_wr;
  logic                nz_seen;
  logic [HEX_W-1:0]    hex_q;
  logic [NUM_FIELDS-1:0] ovf_q;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int o = 0; o < NUM_FIELDS; o++) begin
      if (!pick_vld && pend[(int'(rr_ptr) + o) % NUM_FIELDS]) begin
        pick     = SEL_W'((int'(rr_ptr) + o) % NUM_FIELDS);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    case (state)
      IDLE:  if (pick_vld) state_nxt = LOAD;
      LOAD: begin
        conv_start = 1'b1;
        state_nxt  = SHIFT;
      end
      SHIFT: if (conv_done) state_nxt = WRITE;
      WRITE: state_nxt = pick_vld ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE || state == WRITE) && pick_vld) sel <= pick;
      if (state == LOAD) rr_ptr <= (sel == SEL_W'(NUM_FIELDS - 1)) ? '0 : sel + 1'b1;
    end
  end

  // A load landing on the field being consumed in LOAD keeps it pending with the new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) pend_val[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (field_load[i]) begin
          pend[i]     <= 1'b1;
          pend_val[i] <= field_value[i*DATA_W +: DATA_W];
        end else if (state == LOAD && int'(sel) == i) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  bin2bcd_seq #(.DATA_W(DATA_W), .D(D)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (pend_val[sel]),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf),
    .done  (conv_done)
  );

  // Scan from the top digit down so blanking stops at the first nonzero digit
  always_comb begin
    seg_wr  = '0;
    nz_seen = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      if (conv_bcd[4*k +: 4] != 4'd0) nz_seen = 1'b1;
      if (conv_ovf)
        seg_wr[k*7 +: 7] = SEG_DASH;
      else if (BLANK_LZ != 0 && k != 0 && !nz_seen)
        seg_wr[k*7 +: 7] = SEG_BLANK;
      else
        seg_wr[k*7 +: 7] = seg_encode(conv_bcd[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= HEX_RST;
      ovf_q <= '0;
    end else if (state == WRITE) begin
      hex_q[int'(sel)*D*7 +: D*7] <= seg_wr;
      ovf_q[sel]                  <= conv_ovf;
    end
  end

  assign hex_o    = hex_q;
  assign overflow = ovf_q;
  assign busy     = (state != IDLE) || (|pend);

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl (4 fields, 2 digits, 32-bit values, leading-zero blanking).
module tb_seg_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, BL = 7'b1111111, DA = 7'b0111111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   field_load;
  logic [127:0] field_value;
  logic [55:0]  hex_o;
  logic [3:0]   overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [6:0] m_d0 [4];
  logic [6:0] m_d1 [4];
  logic       m_ov [4];

  seg_display_ctrl #(
    .NUM_FIELDS(4), .DIGITS_PER_FIELD(2), .DATA_W(32), .BLANK_LZ(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .field_load  (field_load),
    .field_value (field_value),
    .hex_o       (hex_o),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dig(input int f, input int k);
    return hex_o[(f*2+k)*7 +: 7];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_d0[i] = S0;
      m_d1[i] = BL;
      m_ov[i] = 1'b0;
    end
  endtask

  task automatic check_field(input string tag, input int f);
    check($sformatf("%s f%0d d0", tag, f), {25'b0, dig(f, 0)}, {25'b0, m_d0[f]});
    check($sformatf("%s f%0d d1", tag, f), {25'b0, dig(f, 1)}, {25'b0, m_d1[f]});
    check($sformatf("%s f%0d ovf", tag, f), {31'b0, overflow[f]}, {31'b0, m_ov[f]});
  endtask

  task automatic check_all(input string tag);
    for (int f = 0; f < 4; f++) check_field(tag, f);
  endtask

  // Drive one load pulse; returns just after the capturing edge
  task automatic load1(input int f, input logic [31:0] v);
    field_value           = '0;
    field_value[f*32 +: 32] = v;
    field_load            = '0;
    field_load[f]         = 1'b1;
    @(posedge clk);
    #1;
    field_load = '0;
  endtask

  // Single conversion from idle: old value held through E+34, new value after E+35
  task automatic conv(input string tag, input int f, input logic [31:0] v,
                      input logic [6:0] e0, input logic [6:0] e1, input logic eovf);
    load1(f, v);
    wait_cyc(34);
    check({tag, " busy mid"}, {31'b0, busy}, 32'd1);
    check_field({tag, " hold"}, f);
    wait_cyc(1);
    m_d0[f] = e0;
    m_d1[f] = e1;
    m_ov[f] = eovf;
    check_all(tag);
    check({tag, " busy done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    field_load  = '0;
    field_value = '0;
    model_reset();
    wait_cyc(3);
    check_all("in_reset");
    rst_n = 1'b1;
    wait_cyc(2);
    check_all("after_reset");
    check("reset busy", {31'b0, busy}, 32'd0);

    conv("val7",   0, 32'd7,         S7, BL, 1'b0);
    conv("val42",  2, 32'd42,        S2, S4, 1'b0);
    conv("val5",   2, 32'd5,         S5, BL, 1'b0);
    conv("val100", 1, 32'd100,       DA, DA, 1'b1);
    conv("val99",  1, 32'd99,        S9, S9, 1'b0);
    conv("valmax", 1, 32'hFFFFFFFF,  DA, DA, 1'b1);
    conv("val10",  3, 32'd10,        S0, S1, 1'b0);
    conv("val0",   3, 32'd0,         S0, BL, 1'b0);

    // Four simultaneous loads from a fresh reset, plus a reload of field 0 mid-conversion
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    model_reset();
    wait_cyc(1);
    field_value = {32'd4, 32'd3, 32'd2, 32'd1};
    field_load  = 4'hF;
    @(posedge clk);
    #1;
    field_load = '0;
    wait_cyc(9);
    load1(0, 32'd8);
    wait_cyc(24);
    check_all("rr pre f0");
    wait_cyc(1);
    m_d0[0] = S1;
    check_all("rr f0");
    wait_cyc(33);
    check_all("rr pre f1");
    wait_cyc(1);
    m_d0[1] = S2;
    check_all("rr f1");
    wait_cyc(33);
    check_all("rr pre f2");
    wait_cyc(1);
    m_d0[2] = S3;
    check_all("rr f2");
    wait_cyc(33);
    check_all("rr pre f3");
    wait_cyc(1);
    m_d0[3] = S4;
    check_all("rr f3");
    check("rr busy reload", {31'b0, busy}, 32'd1);
    wait_cyc(33);
    check_all("rr pre reload");
    wait_cyc(1);
    m_d0[0] = S8;
    check_all("rr reload");
    check("rr busy end", {31'b0, busy}, 32'd0);

    // Reset in the middle of a conversion with another field pending
    load1(3, 32'd42);
    wait_cyc(10);
    load1(1, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    check("midreset busy", {31'b0, busy}, 32'd0);
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(80);
    check_all("postreset");
    check("postreset busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
